// File: rtl/seg_scan_rx.sv
// seg_scan_rx: glitch-filtered decoder for a multiplexed active-low seven-segment display bus
// Ports: clk/rst (async active-low) clock and reset; i_seg/i_an active-low segment bus and anode strobes;
//        i_clr clears the error flag and frame mask; o_digits/o_dp/o_valid/o_blank per-digit decode results;
//        o_upd/o_upd_idx slot-write pulse and index; o_frame all-slots-written pulse; o_err sticky error.
module seg_scan_rx #(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_seg,
    input  logic [7:0]  i_an,
    input  logic        i_clr,
    output logic [31:0] o_digits,
    output logic [7:0]  o_dp,
    output logic [7:0]  o_valid,
    output logic [7:0]  o_blank,
    output logic        o_upd,
    output logic [2:0]  o_upd_idx,
    output logic        o_frame,
    output logic        o_err
);
    localparam logic [7:0] STAB = 8'(STABLE_CYC);
    typedef enum logic {TRACK, HOLD} state_t;
    state_t      state_q, state_d;
    logic [15:0] sync_q, sync_d, samp_q, samp_d;
    logic [7:0]  cnt_q, cnt_d, mask_q, mask_d, dp_q, dp_d, valid_q, valid_d, blank_q, blank_d;
    logic [31:0] digits_q, digits_d;
    logic        upd_q, upd_d, frame_q, frame_d, err_q, err_d;
    logic [2:0]  idx_q, idx_d, idx;
    logic        changed, accept, one_hot, legal, wr, err_set;
    logic [7:0]  sel, mask_n;
    logic [6:0]  seg7;
    logic [3:0]  nib;

    // {legal, nibble}; anything that is not a hex glyph decodes to nibble 0
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1111110: decode = 5'h10;
            7'b0110000: decode = 5'h11;
            7'b1101101: decode = 5'h12;
            7'b1111001: decode = 5'h13;
            7'b0110011: decode = 5'h14;
            7'b1011011: decode = 5'h15;
            7'b1011111: decode = 5'h16;
            7'b1110000: decode = 5'h17;
            7'b1111111: decode = 5'h18;
            7'b1111011: decode = 5'h19;
            7'b1110111: decode = 5'h1A;
            7'b0011111: decode = 5'h1B;
            7'b1001110: decode = 5'h1C;
            7'b0111101: decode = 5'h1D;
            7'b1001111: decode = 5'h1E;
            7'b1000111: decode = 5'h1F;
            default:    decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        sync_d   = {~i_an, ~i_seg};
        samp_d   = sync_q;
        // comparing the incoming sample against the held one saves a cycle of filter latency
        changed  = samp_d != samp_q;
        accept   = !changed && state_q == TRACK && cnt_q == STAB - 8'd1;
        cnt_d    = changed ? 8'd0 : (cnt_q == STAB ? cnt_q : cnt_q + 8'd1);
        state_d  = changed ? TRACK : (accept ? HOLD : state_q);
        sel      = samp_q[15:8];
        seg7     = samp_q[7:1];
        {legal, nib} = decode(seg7);
        one_hot  = sel != 8'd0 && (sel & (sel - 8'd1)) == 8'd0;
        idx      = 3'd0;
        for (int i = 0; i < 8; i++) if (sel[i]) idx = 3'(i);
        wr       = accept && one_hot;
        err_set  = accept && (one_hot ? (!legal && seg7 != 7'd0) : sel != 8'd0);
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        blank_d  = blank_q;
        if (wr) begin
            digits_d[{idx, 2'b00} +: 4] = nib;
            dp_d[idx]    = samp_q[0];
            valid_d[idx] = legal;
            blank_d[idx] = seg7 == 7'd0;
        end
        mask_n   = mask_q | (wr ? 8'd1 << idx : 8'd0);
        frame_d  = !i_clr && mask_n == 8'hFF;
        // a clear keeps only the slot written on the same edge
        mask_d   = i_clr ? (wr ? 8'd1 << idx : 8'd0) : (frame_d ? 8'd0 : mask_n);
        err_d    = !i_clr && (err_q || err_set);
        upd_d    = wr;
        idx_d    = wr ? idx : idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= TRACK;
            sync_q   <= '0;
            samp_q   <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            digits_q <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            blank_q  <= 8'hFF;
            upd_q    <= 1'b0;
            idx_q    <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            samp_q   <= samp_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            blank_q  <= blank_d;
            upd_q    <= upd_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign o_digits  = digits_q;
    assign o_dp      = dp_q;
    assign o_valid   = valid_q;
    assign o_blank   = blank_q;
    assign o_upd     = upd_q;
    assign o_upd_idx = idx_q;
    assign o_frame   = frame_q;
    assign o_err     = err_q;
endmodule

// File: tb/tb_seg_scan_rx.sv
// tb_seg_scan_rx: self-checking bench for seg_scan_rx
// Ports: none; drives every DUT port and compares outputs against a sample-history reference model,
//        a directed vector table and hand-written latency / reset sequences.
module tb_seg_scan_rx;
    localparam int S = 4;
    logic        clk = 1'b0, rst = 1'b0, i_clr = 1'b0;
    logic [7:0]  i_seg = 8'hFF, i_an = 8'hFF;
    logic [31:0] o_digits;
    logic [7:0]  o_dp, o_valid, o_blank;
    logic        o_upd, o_frame, o_err;
    logic [2:0]  o_upd_idx;
    int          errors = 0, checks = 0;

    seg_scan_rx #(.STABLE_CYC(S)) dut (
        .clk(clk), .rst(rst), .i_seg(i_seg), .i_an(i_an), .i_clr(i_clr),
        .o_digits(o_digits), .o_dp(o_dp), .o_valid(o_valid), .o_blank(o_blank),
        .o_upd(o_upd), .o_upd_idx(o_upd_idx), .o_frame(o_frame), .o_err(o_err)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // reference model state; hist[0] is the input seen at the previous edge
    logic [15:0] hist [S+2];
    logic [31:0] m_digits;
    logic [7:0]  m_dp, m_valid, m_blank, m_mask;
    logic        m_upd, m_frame, m_err;
    logic [2:0]  m_idx;

    typedef struct {
        logic [7:0]  an;
        logic [7:0]  seg;
        logic        clr;
        int          cyc;
        int          upd;
        int          frm;
        logic [31:0] dig;
        logic [7:0]  val;
        logic [7:0]  blk;
        logic        err;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [7:0] sg(input int v);
        return ~{glyph[v], 1'b0};
    endfunction

    function automatic vec_t mk(input logic [7:0] an, input logic [7:0] seg, input logic clr, input int cyc,
                                input int upd, input int frm, input logic [31:0] dig, input logic [7:0] val,
                                input logic [7:0] blk, input logic err);
        vec_t v;
        v.an = an; v.seg = seg; v.clr = clr; v.cyc = cyc; v.upd = upd; v.frm = frm;
        v.dig = dig; v.val = val; v.blk = blk; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_digits = '0; m_dp = '0; m_valid = '0; m_blank = 8'hFF; m_mask = '0;
        m_upd = 1'b0; m_frame = 1'b0; m_err = 1'b0; m_idx = '0;
        for (int k = 0; k < S + 2; k++) hist[k] = '0;
    endtask

    // a write happens on the edge where the last S+1 samples agree and the one before them differed
    task automatic model_edge();
        logic       acc, wr, set_err;
        logic [7:0] sel, bit_n;
        logic [6:0] seg7;
        int         n, val;
        acc = hist[S + 1] != hist[S];
        for (int k = 1; k <= S; k++) if (hist[k] != hist[0]) acc = 1'b0;
        sel = hist[0][15:8]; seg7 = hist[0][7:1];
        wr = 1'b0; set_err = 1'b0; m_upd = 1'b0; m_frame = 1'b0; n = 0; val = -1;
        for (int k = 0; k < 8; k++) if (sel[k]) n = k;
        for (int k = 0; k < 16; k++) if (glyph[k] == seg7) val = k;
        bit_n = 8'd1 << n;
        if (acc && $countones(sel) > 1) set_err = 1'b1;
        if (acc && $countones(sel) == 1) begin
            wr = 1'b1; m_upd = 1'b1; m_idx = 3'(n);
            m_dp[n] = hist[0][0];
            m_digits[4*n +: 4] = val >= 0 ? 4'(val) : 4'd0;
            m_valid[n] = val >= 0;
            m_blank[n] = seg7 == 7'd0;
            if (val < 0 && seg7 != 7'd0) set_err = 1'b1;
        end
        if (i_clr) begin
            m_err = 1'b0;
            m_mask = wr ? bit_n : 8'd0;
        end else begin
            m_err = m_err | set_err;
            if (wr) m_mask = m_mask | bit_n;
            if (m_mask == 8'hFF) begin m_frame = 1'b1; m_mask = '0; end
        end
        for (int k = S + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = {~i_an, ~i_seg};
    endtask

    task automatic compare_all();
        chk("digits", o_digits, m_digits);
        chk("dp", {24'd0, o_dp}, {24'd0, m_dp});
        chk("valid", {24'd0, o_valid}, {24'd0, m_valid});
        chk("blank", {24'd0, o_blank}, {24'd0, m_blank});
        chk("upd", {31'd0, o_upd}, {31'd0, m_upd});
        chk("frame", {31'd0, o_frame}, {31'd0, m_frame});
        chk("err", {31'd0, o_err}, {31'd0, m_err});
        if (m_upd) chk("upd_idx", {29'd0, o_upd_idx}, {29'd0, m_idx});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge(); else model_reset();
        #1;
        compare_all();
    endtask

    task automatic chk_reset();
        chk("rst_digits", o_digits, 32'd0);
        chk("rst_dp", {24'd0, o_dp}, 32'd0);
        chk("rst_valid", {24'd0, o_valid}, 32'd0);
        chk("rst_blank", {24'd0, o_blank}, 32'h0000_00FF);
        chk("rst_upd", {31'd0, o_upd}, 32'd0);
        chk("rst_idx", {29'd0, o_upd_idx}, 32'd0);
        chk("rst_frame", {31'd0, o_frame}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
    endtask

    initial begin
        int first, ups, frms;
        model_reset();
        i_an = 8'($urandom); i_seg = 8'($urandom); i_clr = 1'($urandom);
        #12;
        chk_reset();
        tick();
        i_clr = 1'b0; i_an = 8'hFF; i_seg = 8'hFF;
        rst = 1'b1;
        repeat (8) tick();

        // single digit "2" on slot 2: the pulse lands after the sixth edge
        i_an = 8'hFB; i_seg = ~8'b11011010;
        first = -1; ups = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_upd && first < 0) first = i;
            ups += int'(o_upd);
        end
        chk("lat_first", 32'(first), 32'd5);
        chk("lat_count", 32'(ups), 32'd1);
        chk("lat_nibble", {28'd0, o_digits[11:8]}, 32'd2);
        chk("lat_valid", {31'd0, o_valid[2]}, 32'd1);
        chk("lat_dp", {31'd0, o_dp[2]}, 32'd0);

        tbl.push_back(mk(8'hFE, sg(7), 1'b0, 3, 0, 0, 32'h0000_0200, 8'h04, 8'hFB, 1'b0));
        tbl.push_back(mk(8'hFF, 8'hFF, 1'b0, 10, 0, 0, 32'h0000_0200, 8'h04, 8'hFB, 1'b0));
        tbl.push_back(mk(8'hFE, sg(0), 1'b0, 8, 1, 0, 32'h0000_0200, 8'h05, 8'hFA, 1'b0));
        tbl.push_back(mk(8'hFD, sg(1), 1'b0, 8, 1, 0, 32'h0000_0210, 8'h07, 8'hF8, 1'b0));
        tbl.push_back(mk(8'hFB, sg(7), 1'b0, 8, 1, 0, 32'h0000_0710, 8'h07, 8'hF8, 1'b0));
        tbl.push_back(mk(8'hF7, sg(6), 1'b0, 8, 1, 0, 32'h0000_6710, 8'h0F, 8'hF0, 1'b0));
        tbl.push_back(mk(8'hEF, sg(4), 1'b0, 8, 1, 0, 32'h0004_6710, 8'h1F, 8'hE0, 1'b0));
        tbl.push_back(mk(8'hDF, sg(5), 1'b0, 8, 1, 0, 32'h0054_6710, 8'h3F, 8'hC0, 1'b0));
        tbl.push_back(mk(8'hBF, sg(3), 1'b0, 8, 1, 0, 32'h0354_6710, 8'h7F, 8'h80, 1'b0));
        tbl.push_back(mk(8'h7F, sg(2), 1'b0, 8, 1, 1, 32'h2354_6710, 8'hFF, 8'h00, 1'b0));
        tbl.push_back(mk(8'hF3, sg(8), 1'b0, 8, 0, 0, 32'h2354_6710, 8'hFF, 8'h00, 1'b1));
        tbl.push_back(mk(8'hDF, ~8'b10101010, 1'b0, 8, 1, 0, 32'h2304_6710, 8'hDF, 8'h00, 1'b1));
        tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 1, 0, 0, 32'h2304_6710, 8'hDF, 8'h00, 1'b0));
        tbl.push_back(mk(8'hEF, 8'hFF, 1'b0, 8, 1, 0, 32'h2300_6710, 8'hCF, 8'h10, 1'b0));

        foreach (tbl[t]) begin
            i_an = tbl[t].an; i_seg = tbl[t].seg; i_clr = tbl[t].clr;
            ups = 0; frms = 0;
            for (int c = 0; c < tbl[t].cyc; c++) begin
                tick();
                i_clr = 1'b0;
                ups += int'(o_upd);
                frms += int'(o_frame);
            end
            chk($sformatf("tbl%0d_upd", t), 32'(ups), 32'(tbl[t].upd));
            chk($sformatf("tbl%0d_frame", t), 32'(frms), 32'(tbl[t].frm));
            chk($sformatf("tbl%0d_digits", t), o_digits, tbl[t].dig);
            chk($sformatf("tbl%0d_valid", t), {24'd0, o_valid}, {24'd0, tbl[t].val});
            chk($sformatf("tbl%0d_blank", t), {24'd0, o_blank}, {24'd0, tbl[t].blk});
            chk($sformatf("tbl%0d_err", t), {31'd0, o_err}, {31'd0, tbl[t].err});
        end

        // reset mid-count discards the pending write; a short hold afterwards must not write
        i_an = 8'hF7; i_seg = sg(9);
        repeat (3) tick();
        #2;
        rst = 1'b0;
        model_reset();
        i_an = 8'($urandom); i_seg = 8'($urandom);
        #1;
        chk_reset();
        tick();
        tick();
        i_an = 8'hF7; i_seg = sg(9);
        rst = 1'b1;
        ups = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 4) begin i_an = 8'hFF; i_seg = 8'hFF; end
            tick();
            ups += int'(o_upd);
        end
        chk("rst_no_upd", 32'(ups), 32'd0);

        for (int it = 0; it < 300; it++) begin
            int kind, d, hold, a, b;
            kind = $urandom_range(0, 9);
            d = $urandom_range(0, 7);
            i_an = ~(8'd1 << d);
            i_seg = sg($urandom_range(0, 15)) ^ {7'd0, 1'($urandom)};
            if (kind == 6) i_seg = 8'($urandom);
            if (kind == 7) i_seg = 8'hFF ^ {7'd0, 1'($urandom)};
            if (kind == 8) i_an = 8'hFF;
            if (kind == 9) begin
                a = $urandom_range(0, 7);
                b = (a + 1 + $urandom_range(0, 6)) % 8;
                i_an = ~(8'($urandom) | (8'd1 << a) | (8'd1 << b));
            end
            hold = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) begin
                i_clr = $urandom_range(0, 15) == 0;
                tick();
            end
            i_clr = 1'b0;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                compare_all();
                tick();
                rst = 1'b1;
            end
        end
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
